// File: rtl/logic_pkg.sv
// logic_pkg: gate-select encodings and the single-bit gate evaluator shared by
// the pipelined logic unit and its reference model.
`default_nettype none

package logic_pkg;

   typedef enum logic [2:0] {
      OP_NAND = 3'd0,
      OP_NOT  = 3'd1,
      OP_AND  = 3'd2,
      OP_OR   = 3'd3,
      OP_XOR  = 3'd4,
      OP_NOR  = 3'd5,
      OP_XNOR = 3'd6,
      OP_PASS = 3'd7
   } op_e;

   localparam int OP_WIDTH = 3;

   // Every function is bitwise, so one bit slice fully defines the operation.
   function automatic logic logic_eval(input logic [OP_WIDTH-1:0] op,
                                       input logic a, input logic b);
      logic r;
      case (op)
         OP_NAND: r = ~(a & b);
         OP_NOT:  r = ~a;
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         default: r = a;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pipe_stage.sv
// pipe_stage: one valid+data register with load enable and synchronous reset.
`default_nettype none

module pipe_stage #(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             en,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d_data,
   output logic             q_valid,
   output logic [WIDTH-1:0] q_data
);

   always_ff @(posedge clock) begin
      if (reset) begin
         q_valid <= 1'b0;
         q_data  <= '0;
      end else if (en) begin
         q_valid <= d_valid;
         q_data  <= d_data;
      end
   end

endmodule

`default_nettype wire

// File: rtl/logic_pipe.sv
// logic_pipe: bitwise gate unit feeding a STAGES-deep valid/ready pipeline,
// with zero/negative flags on the output and a delivered-result counter.
`default_nettype none

module logic_pipe
   import logic_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int STAGES = 2
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zr,
   output logic             ng,
   output logic [15:0]      done_cnt
);

   logic             advance;
   logic [WIDTH-1:0] func;
   logic             vld [STAGES+1];
   logic [WIDTH-1:0] dat [STAGES+1];

   always_comb begin
      func = '0;
      for (int i = 0; i < WIDTH; i++) begin
         func[i] = logic_eval(op, a[i], b[i]);
      end
   end

   // A single global advance keeps every stage (bubbles included) in lockstep,
   // so the output register only changes when the consumer takes it or it is empty.
   assign advance  = out_ready | ~out_valid;
   assign in_ready = advance;

   assign vld[0] = in_valid;
   assign dat[0] = func;

   generate
      for (genvar i = 0; i < STAGES; i++) begin : g_stage
         pipe_stage #(
            .WIDTH (WIDTH)
         ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .en      (advance),
            .d_valid (vld[i]),
            .d_data  (dat[i]),
            .q_valid (vld[i+1]),
            .q_data  (dat[i+1])
         );
      end
   endgenerate

   assign out_valid = vld[STAGES];
   assign y         = dat[STAGES];
   assign zr        = (y == '0);
   assign ng        = y[WIDTH-1];

   always_ff @(posedge clock) begin
      if (reset) begin
         done_cnt <= 16'd0;
      end else if (out_valid && out_ready) begin
         done_cnt <= done_cnt + 16'd1;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_logic_pipe.sv
// tb_logic_pipe: directed and randomized checks of logic_pipe against a
// word-level gate model with an in-order queue of expected results.
`default_nettype none

module tb_logic_pipe;

   localparam int W = 16;
   localparam int S = 2;

   logic          clock = 1'b0;
   logic          reset;
   logic          in_valid, in_ready, out_valid, out_ready, zr, ng;
   logic [2:0]    op;
   logic [W-1:0]  a, b, y;
   logic [15:0]   done_cnt;

   logic          s_in_valid;
   logic [2:0]    s_op;
   logic [7:0]    s_a, s_b;
   logic          s_rdy1, s_ov1, s_zr1, s_ng1, s_rdy4, s_ov4, s_zr4, s_ng4;
   logic [7:0]    s_y1, s_y4;
   logic [15:0]   s_cnt1, s_cnt4;

   always #5 clock = ~clock;

   logic_pipe #(.WIDTH(W), .STAGES(S)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zr(zr), .ng(ng), .done_cnt(done_cnt)
   );

   logic_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
      .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_rdy1),
      .op(s_op), .a(s_a), .b(s_b), .out_valid(s_ov1), .out_ready(1'b1),
      .y(s_y1), .zr(s_zr1), .ng(s_ng1), .done_cnt(s_cnt1)
   );

   logic_pipe #(.WIDTH(8), .STAGES(4)) dut4 (
      .clock(clock), .reset(reset), .in_valid(s_in_valid), .in_ready(s_rdy4),
      .op(s_op), .a(s_a), .b(s_b), .out_valid(s_ov4), .out_ready(1'b1),
      .y(s_y4), .zr(s_zr4), .ng(s_ng4), .done_cnt(s_cnt4)
   );

   typedef struct {
      logic [W-1:0] d;
      int           t;
   } ent_t;

   ent_t         q[$];
   int           compared = 0;
   int           mismatched = 0;
   int           cyc = 0;
   int           delivered = 0;
   int           stall_left = 0;
   logic [15:0]  cnt_m = 16'd0;
   logic [W-1:0] cur_exp;
   logic [W-1:0] prev_y;
   logic         prev_hold = 1'b0;
   logic         acc_last = 1'b0;
   logic         strict_lat = 1'b0;
   logic         rand_ready = 1'b0;

   logic [W-1:0] sweep_exp [8] = '{16'hFFF0, 16'hFF00, 16'h000F, 16'h0FFF,
                                   16'h0FF0, 16'hF000, 16'hF00F, 16'h00FF};

   function automatic logic [63:0] ref_gate(input int k, input logic [63:0] x, input logic [63:0] z);
      case (k)
         0:       return ~(x & z);
         1:       return ~x;
         2:       return x & z;
         3:       return x | z;
         4:       return x ^ z;
         5:       return ~(x | z);
         6:       return ~(x ^ z);
         default: return x;
      endcase
   endfunction

   function automatic logic [W-1:0] ref16(input int k, input logic [W-1:0] x, input logic [W-1:0] z);
      logic [63:0] r;
      r = ref_gate(k, {48'd0, x}, {48'd0, z});
      return r[W-1:0];
   endfunction

   function automatic logic [7:0] ref8(input int k);
      logic [63:0] r;
      r = ref_gate(k, 64'h0F, 64'h33);
      return r[7:0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Samples just after the falling edge, books handshakes, then crosses one rising edge.
   task automatic tick();
      logic exp_rdy;
      ent_t e;
      #1;
      acc_last = 1'b0;
      if (!reset) begin
         exp_rdy = out_ready || !out_valid;
         chk("done_cnt", done_cnt, cnt_m);
         chk("in_ready", in_ready, exp_rdy);
         if (prev_hold) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_y", y, prev_y);
         end
         if (out_valid) begin
            if (q.size() == 0) begin
               chk("spurious_valid", out_valid, 0);
            end else begin
               e = q[0];
               chk("y", y, e.d);
               chk("zr", zr, e.d == '0);
               chk("ng", ng, e.d[W-1]);
               if (strict_lat && out_ready) chk("latency", cyc - e.t, S);
            end
         end else if (strict_lat && q.size() > 0) begin
            chk("overdue", (cyc - q[0].t) < S, 1);
         end
         if (out_valid && out_ready && q.size() > 0) begin
            void'(q.pop_front());
            cnt_m++;
            delivered++;
         end
         if (in_valid && in_ready) begin
            q.push_back('{d: cur_exp, t: cyc});
            acc_last = 1'b1;
         end
         prev_hold = out_valid && !out_ready;
         prev_y    = y;
      end
      @(posedge clock);
      cyc++;
      @(negedge clock);
      if (stall_left > 0 && out_valid) begin
         out_ready = 1'b0;
         stall_left--;
      end else begin
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic drive(input int k, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] exp);
      op      = 3'(k);
      a       = xa;
      b       = xb;
      cur_exp = exp;
   endtask

   task automatic send(input int k, input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] exp);
      drive(k, xa, xb, exp);
      in_valid = 1'b1;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (acc_last) return;
      end
      chk("accept_timeout", 0, 1);
   endtask

   task automatic send_rand();
      int k;
      logic [W-1:0] xa, xb;
      k  = int'($urandom_range(0, 7));
      xa = W'($urandom);
      xb = W'($urandom);
      send(k, xa, xb, ref16(k, xa, xb));
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int n = 0; n < 60; n++) begin
         if (q.size() == 0 && !out_valid) break;
         tick();
      end
      chk("drain_empty", q.size(), 0);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) begin
         @(posedge clock);
         @(negedge clock);
      end
      #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 16'h0000);
      chk("rst_zr", zr, 1);
      chk("rst_ng", ng, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_s1_valid", s_ov1, 0);
      chk("rst_s4_valid", s_ov4, 0);
      reset     = 1'b0;
      q.delete();
      cnt_m     = 16'd0;
      prev_hold = 1'b0;
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      op = 3'd0; a = '0; b = '0; cur_exp = '0; prev_y = '0;
      s_in_valid = 1'b0; s_op = 3'd0; s_a = 8'h0F; s_b = 8'h33;
      @(negedge clock);
      do_reset();

      // Op sweep and flag cases, exact two-cycle latency.
      strict_lat = 1'b1;
      for (int k = 0; k < 8; k++) send(k, 16'h00FF, 16'h0F0F, sweep_exp[k]);
      send(2, 16'hAAAA, 16'h5555, 16'h0000);
      send(3, 16'hAAAA, 16'h5555, 16'hFFFF);
      drain();
      strict_lat = 1'b0;

      // Backpressure: three stalled cycles with a full output.
      do_reset();
      send_rand();
      send_rand();
      out_ready  = 1'b0;
      stall_left = 2;
      send_rand();
      send_rand();
      drain();
      chk("bp_done_cnt", done_cnt, 16'd4);

      // Random traffic with a mid-stream reset.
      rand_ready = 1'b1;
      for (int i = 0; i < 150; i++) begin
         if (i == 75) begin
            drive(4, 16'h1234, 16'h4321, 16'h5115);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            do_reset();
         end
         if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            tick();
         end else begin
            send_rand();
         end
      end
      rand_ready = 1'b0;
      drain();

      // Depth sweep on the STAGES=1 and STAGES=4 instances.
      do_reset();
      for (int t = 0; t < 14; t++) begin
         s_in_valid = (t < 8);
         s_op       = 3'(t);
         #1;
         chk("d1_valid", s_ov1, (t >= 1 && t <= 8));
         if (t >= 1 && t <= 8) chk("d1_y", s_y1, ref8(t - 1));
         if (t == 5) chk("d1_xor", s_y1, 8'h3C);
         chk("d4_valid", s_ov4, (t >= 4 && t <= 11));
         if (t >= 4 && t <= 11) chk("d4_y", s_y4, ref8(t - 4));
         if (t == 8) chk("d4_xor", s_y4, 8'h3C);
         @(posedge clock);
         @(negedge clock);
      end
      s_in_valid = 1'b0;
      chk("d1_cnt", s_cnt1, 16'd8);
      chk("d4_cnt", s_cnt4, 16'd8);

      // Counter wrap after 65537 deliveries.
      do_reset();
      delivered = 0;
      n = 0;
      in_valid = 1'b1;
      while (delivered < 65537 && n < 70000) begin
         drive(7, W'($urandom), 16'h0000, '0);
         cur_exp = a;
         tick();
         n++;
      end
      in_valid = 1'b0;
      chk("wrap_deliveries", delivered, 65537);
      chk("wrap_done_cnt", done_cnt, 16'h0001);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

`default_nettype wire
